// File: rtl/regfile_write_arbiter_if.sv
// Interface between the two writeback requesters, the write-port arbiter and
// the register file. The arbiter connects through the slave modport. The
// master modport is the requester/register-file side, which drives the
// requests and observes the write port and the pending mask.
interface regfile_write_arbiter_if #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
);
   localparam int NREGS = 1 << RADDR_W;

   // Requester 0: ALU/load writeback
   logic               req0_valid;
   logic               req0_ready;
   logic [RADDR_W-1:0] req0_rd;
   logic [XLEN-1:0]    req0_data;

   // Requester 1: multi-cycle unit (mul/div)
   logic               req1_valid;
   logic               req1_ready;
   logic [RADDR_W-1:0] req1_rd;
   logic [XLEN-1:0]    req1_data;

   // Register file write port
   logic               reg_write;
   logic [RADDR_W-1:0] write_reg;
   logic [XLEN-1:0]    write_data;

   // Outstanding buffered destinations, one bit per register
   logic [NREGS-1:0]   pending;

   modport master (
      output req0_valid, req0_rd, req0_data,
      input  req0_ready,
      output req1_valid, req1_rd, req1_data,
      input  req1_ready,
      input  reg_write, write_reg, write_data,
      input  pending
   );

   modport slave (
      input  req0_valid, req0_rd, req0_data,
      output req0_ready,
      input  req1_valid, req1_rd, req1_data,
      output req1_ready,
      output reg_write, write_reg, write_data,
      output pending
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port between the ALU/load writeback
// path (requester 0) and the mul/div unit (requester 1). Each requester owns
// a one-entry holding buffer. One buffered write is issued per cycle.
// Writes to x0 are accepted and then discarded.
//
// Build option:
//   WB_ARB_ROUND_ROBIN_EN  defined   -> both buffers valid: strict alternation
//                          undefined -> both buffers valid: requester 0 wins
// The most-recent-grant bit is kept in both builds. The fixed-priority build
// does not use it for arbitration.
module regfile_write_arbiter #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   regfile_write_arbiter_if.slave bus
);
   localparam int NREGS = 1 << RADDR_W;

   // Holding buffers: the valid bits are control state. Address and data are
   // payload only.
   logic [1:0]         r_buf_v;
   logic [RADDR_W-1:0] r_buf_rd   [2];
   logic [XLEN-1:0]    r_buf_data [2];
   // 0/1 = requester granted most recently; reset to 1 so requester 0 wins first
   logic               r_last_gnt;

   // Requests viewed as small arrays indexed by requester
   logic [1:0]         w_req_valid;
   logic [RADDR_W-1:0] w_req_rd   [2];
   logic [XLEN-1:0]    w_req_data [2];

   logic [1:0]         w_gnt;       // one-hot grant among valid buffers
   logic               w_issue;     // a write goes out this cycle
   logic               w_sel;       // index of the granted buffer
   logic [1:0]         w_ready;
   logic [1:0]         w_xfer;      // handshake completes at the next edge
   logic [1:0]         w_load;      // transfer that actually fills a buffer
   logic [NREGS-1:0]   w_pending;

   // Grant decision for a pair of valid bits. The result depends only on
   // registered state, so no request input reaches the write port
   // combinationally.
   function automatic logic [1:0] arb_grant(input logic [1:0] v,
                                            input logic       last);
      logic [1:0] g;
      g = 2'b00;
      case (v)
         2'b01:   g = 2'b01;
         2'b10:   g = 2'b10;
         2'b11: begin
`ifdef WB_ARB_ROUND_ROBIN_EN
            g = last ? 2'b01 : 2'b10;
`else
            g = last ? 2'b01 : 2'b01;
`endif
         end
         default: g = 2'b00;
      endcase
      return g;
   endfunction

   // Next valid bit for one buffer.
   // A nonzero transfer refills the buffer. A granted buffer drains.
   // Otherwise the buffer holds.
   function automatic logic buf_next_v(input logic cur_v,
                                       input logic load,
                                       input logic gnt);
      logic nv;
      if (load)
         nv = 1'b1;
      else if (gnt)
         nv = 1'b0;
      else
         nv = cur_v;
      return nv;
   endfunction

   // Gather the two request channels into indexable form
   always_comb begin
      w_req_valid   = {bus.req1_valid, bus.req0_valid};
      w_req_rd[0]   = bus.req0_rd;
      w_req_rd[1]   = bus.req1_rd;
      w_req_data[0] = bus.req0_data;
      w_req_data[1] = bus.req1_data;
   end

   // Arbitration between the holding buffers
   always_comb begin
      w_gnt   = arb_grant(r_buf_v, r_last_gnt);
      w_issue = !reset && (w_gnt != 2'b00);
      w_sel   = w_gnt[1];
   end

   // Handshake: a buffer accepts when it is empty or is draining this cycle.
   // Requests with rd == 0 handshake normally but never load.
   always_comb begin
      w_ready = 2'b00;
      w_xfer  = 2'b00;
      w_load  = 2'b00;
      for (int i = 0; i < 2; i++) begin
         w_ready[i] = !reset && (!r_buf_v[i] || w_gnt[i]);
         w_xfer[i]  = w_ready[i] && w_req_valid[i];
         w_load[i]  = w_xfer[i] && (w_req_rd[i] != '0);
      end
   end

   // Pending-destination mask for hazard logic; x0 never appears
   always_comb begin
      w_pending = '0;
      if (!reset) begin
         for (int r = 1; r < NREGS; r++) begin
            for (int i = 0; i < 2; i++) begin
               if (r_buf_v[i] && (r_buf_rd[i] == RADDR_W'(r)))
                  w_pending[r] = 1'b1;
            end
         end
      end
   end

   // Drive the register-file port and the ready/pending outputs
   always_comb begin
      bus.req0_ready = w_ready[0];
      bus.req1_ready = w_ready[1];
      bus.reg_write  = w_issue;
      bus.write_reg  = w_issue ? r_buf_rd[w_sel]   : '0;
      bus.write_data = w_issue ? r_buf_data[w_sel] : '0;
      bus.pending    = w_pending;
   end

   // Control state: buffer valid bits and most-recent grant; reset discards
   // buffered writes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_buf_v    <= 2'b00;
         r_last_gnt <= 1'b1;
      end else begin
         r_buf_v[0] <= buf_next_v(r_buf_v[0], w_load[0], w_gnt[0]);
         r_buf_v[1] <= buf_next_v(r_buf_v[1], w_load[1], w_gnt[1]);
         r_last_gnt <= w_issue ? w_sel : r_last_gnt;
      end
   end

   // Payload capture; only meaningful while the matching valid bit is set
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (w_load[i]) begin
            r_buf_rd[i]   <= w_req_rd[i];
            r_buf_data[i] <= w_req_data[i];
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: table-driven cycle trace plus
// hand-written multi-cycle sequences (contention, mid-operation reset).
module tb_regfile_write_arbiter;
   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;
   localparam int NREGS   = 1 << RADDR_W;

   logic clk;
   logic reset;

   regfile_write_arbiter_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();

   regfile_write_arbiter #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string              name;
      logic               rst;
      logic               v0;
      logic [RADDR_W-1:0] rd0;
      logic [XLEN-1:0]    d0;
      logic               v1;
      logic [RADDR_W-1:0] rd1;
      logic [XLEN-1:0]    d1;
      logic               e_rdy0;
      logic               e_rdy1;
      logic               e_we;
      logic [RADDR_W-1:0] e_wreg;
      logic [XLEN-1:0]    e_wdata;
      logic [NREGS-1:0]   e_pend;
   } vec_t;

   vec_t vecs[$];
   int   n_checks;
   int   n_errors;

   function automatic vec_t mk(input string name, input logic rst,
                               input logic v0, input logic [RADDR_W-1:0] rd0, input logic [XLEN-1:0] d0,
                               input logic v1, input logic [RADDR_W-1:0] rd1, input logic [XLEN-1:0] d1,
                               input logic e_rdy0, input logic e_rdy1, input logic e_we,
                               input logic [RADDR_W-1:0] e_wreg, input logic [XLEN-1:0] e_wdata,
                               input logic [NREGS-1:0] e_pend);
      vec_t v;
      v.name = name; v.rst = rst;
      v.v0 = v0; v.rd0 = rd0; v.d0 = d0;
      v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
      v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_we = e_we;
      v.e_wreg = e_wreg; v.e_wdata = e_wdata; v.e_pend = e_pend;
      return v;
   endfunction

   function automatic logic [NREGS-1:0] bit_of(input int r);
      logic [NREGS-1:0] m;
      m = '0;
      m[r] = 1'b1;
      return m;
   endfunction

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs after the falling edge, then compare outputs
   task automatic run_vec(input vec_t v);
      @(negedge clk);
      reset          = v.rst;
      bus.req0_valid = v.v0;
      bus.req0_rd    = v.rd0;
      bus.req0_data  = v.d0;
      bus.req1_valid = v.v1;
      bus.req1_rd    = v.rd1;
      bus.req1_data  = v.d1;
      #1;
      check({v.name, ".rdy0"},  XLEN'(bus.req0_ready), XLEN'(v.e_rdy0));
      check({v.name, ".rdy1"},  XLEN'(bus.req1_ready), XLEN'(v.e_rdy1));
      check({v.name, ".we"},    XLEN'(bus.reg_write),  XLEN'(v.e_we));
      check({v.name, ".wreg"},  XLEN'(bus.write_reg),  XLEN'(v.e_wreg));
      check({v.name, ".wdata"}, bus.write_data,        v.e_wdata);
      check({v.name, ".pend"},  XLEN'(bus.pending),    XLEN'(v.e_pend));
   endtask

   // Expected per-cycle results of the contention sequence
   logic [RADDR_W-1:0] c_wreg [4];
   logic               c_rdy0 [4];
   logic               c_rdy1 [4];

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_rd = '0; bus.req0_data = '0;
      bus.req1_valid = 1'b0; bus.req1_rd = '0; bus.req1_data = '0;

      // ---------------- table: reset, single writes, x0, streaming ----------------
      //               name      rst v0 rd0 d0               v1 rd1 d1       rdy0 rdy1 we wreg wdata          pend
      vecs.push_back(mk("rst0",  1, 1, 5, 32'hAA,          0, 0, 0,        0, 0, 0, 0, 0,             '0));
      vecs.push_back(mk("rst1",  1, 1, 5, 32'hAA,          0, 0, 0,        0, 0, 0, 0, 0,             '0));
      vecs.push_back(mk("first", 0, 1, 2, 32'h11,          0, 0, 0,        1, 1, 0, 0, 0,             '0));
      vecs.push_back(mk("wr2",   0, 1, 5, 32'hDEADBEEF,    0, 0, 0,        1, 1, 1, 2, 32'h11,        bit_of(2)));
      vecs.push_back(mk("wr5",   0, 0, 0, 0,               0, 0, 0,        1, 1, 1, 5, 32'hDEADBEEF,  bit_of(5)));
      vecs.push_back(mk("idle5", 0, 0, 0, 0,               0, 0, 0,        1, 1, 0, 0, 0,             '0));
      vecs.push_back(mk("x0acc", 0, 0, 0, 0,               1, 0, 32'h1234, 1, 1, 0, 0, 0,             '0));
      vecs.push_back(mk("x0drp", 0, 0, 0, 0,               0, 0, 0,        1, 1, 0, 0, 0,             '0));
      vecs.push_back(mk("s1",    0, 1, 1, 32'h101,         0, 0, 0,        1, 1, 0, 0, 0,             '0));
      for (int k = 2; k <= 8; k++)
         vecs.push_back(mk($sformatf("s%0d", k), 0, 1, RADDR_W'(k), XLEN'(32'h100 + k), 0, 0, 0,
                           1, 1, 1, RADDR_W'(k - 1), XLEN'(32'h100 + k - 1), bit_of(k - 1)));
      vecs.push_back(mk("sEnd",  0, 0, 0, 0,               0, 0, 0,        1, 1, 1, 8, 32'h108,       bit_of(8)));
      vecs.push_back(mk("sIdle", 0, 0, 0, 0,               0, 0, 0,        1, 1, 0, 0, 0,             '0));
      vecs.push_back(mk("r1acc", 0, 0, 0, 0,               1, 9, 32'h99,   1, 1, 0, 0, 0,             '0));
      vecs.push_back(mk("r1wr",  0, 0, 0, 0,               0, 0, 0,        1, 1, 1, 9, 32'h99,        bit_of(9)));
      vecs.push_back(mk("r1idl", 0, 0, 0, 0,               0, 0, 0,        1, 1, 0, 0, 0,             '0));

      foreach (vecs[i]) run_vec(vecs[i]);

      // ---------------- contention: rd 3 (req0) vs rd 7 (req1) ----------------
`ifdef WB_ARB_ROUND_ROBIN_EN
      c_wreg = '{5'd3, 5'd7, 5'd3, 5'd7};
      c_rdy0 = '{1'b1, 1'b0, 1'b1, 1'b0};
      c_rdy1 = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      c_wreg = '{5'd3, 5'd3, 5'd3, 5'd3};
      c_rdy0 = '{1'b1, 1'b1, 1'b1, 1'b1};
      c_rdy1 = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      run_vec(mk("cLoad", 0, 1, 3, 32'h30, 1, 7, 32'h70, 1, 1, 0, 0, 0, '0));
      for (int c = 0; c < 4; c++)
         run_vec(mk($sformatf("c%0d", c), 0, 1, 3, 32'h30, 1, 7, 32'h70,
                    c_rdy0[c], c_rdy1[c], 1, c_wreg[c],
                    (c_wreg[c] == 5'd3) ? 32'h30 : 32'h70, bit_of(3) | bit_of(7)));
      run_vec(mk("cF", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 32'h30, bit_of(3) | bit_of(7)));
      run_vec(mk("cG", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 32'h70, bit_of(7)));
      run_vec(mk("cH", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, '0));

      // ---------------- reset with buffered writes outstanding ----------------
      run_vec(mk("mLoad", 0, 1, 10, 32'hA0, 1, 11, 32'hB0, 1, 1, 0, 0, 0, '0));
      run_vec(mk("mWr",   0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 10, 32'hA0, bit_of(10) | bit_of(11)));
      run_vec(mk("mRst",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
      run_vec(mk("mPost", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, '0));
      // last grant returns to requester 1 on reset, so requester 0 wins next
      run_vec(mk("pLoad", 0, 1, 12, 32'hC0, 1, 13, 32'hD0, 1, 1, 0, 0, 0, '0));
      run_vec(mk("pW0",   0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 12, 32'hC0, bit_of(12) | bit_of(13)));
      run_vec(mk("pW1",   0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 13, 32'hD0, bit_of(13)));
      run_vec(mk("pIdle", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, '0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
